// File: rtl/exec_pipe.sv
`timescale 1ns/1ps
// exec_pipe: DEPTH-stage registered execute pipeline with per-stage valid
// bits, stall/flush control and hazard/forwarding taps.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   in_*                stage-0 capture: valid, ALU result, zero/overflow
//                       flags, branch target, destination, write request
//   stall, flush        hold all stages / kill all stages (flush wins)
//   out_valid .. dst    last-stage fields, forced to 0 when not valid
//   regwrite            last-stage effective write enable
//   stage_dst/stage_wr  per-stage effective destination and write enable
//   exc_pending         some valid stage holds an overflowing instruction
module exec_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DST_W  = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_aluresult,
  input  logic                   in_zero,
  input  logic                   in_overflow,
  input  logic [ADDR_W-1:0]      in_new_pc,
  input  logic [DST_W-1:0]       in_dst,
  input  logic                   in_regwrite,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      aluresult,
  output logic                   zero,
  output logic                   overflow,
  output logic [ADDR_W-1:0]      new_pc,
  output logic [DST_W-1:0]       dst,
  output logic                   regwrite,
  output logic [DEPTH*DST_W-1:0] stage_dst,
  output logic [DEPTH-1:0]       stage_wr,
  output logic                   exc_pending
);

  localparam int unsigned LAST = DEPTH - 1;

  logic              vld_q  [DEPTH];
  logic              wr_q   [DEPTH];
  logic              zero_q [DEPTH];
  logic              ovf_q  [DEPTH];
  logic [DATA_W-1:0] res_q  [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [DST_W-1:0]  dst_q  [DEPTH];

  logic              in_wr_c;
  logic [DEPTH-1:0]  exc_vec_c;

  // Overflowing instructions and writes to r0 never commit a register write.
  assign in_wr_c = in_valid & in_regwrite & ~in_overflow & (in_dst != '0);

  // Stage registers: flush clears valid bits only, stall holds everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        vld_q[i]  <= 1'b0;
        wr_q[i]   <= 1'b0;
        zero_q[i] <= 1'b0;
        ovf_q[i]  <= 1'b0;
        res_q[i]  <= '0;
        pc_q[i]   <= '0;
        dst_q[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        vld_q[i] <= 1'b0;
      end
    end else if (!stall) begin
      vld_q[0]  <= in_valid;
      wr_q[0]   <= in_wr_c;
      zero_q[0] <= in_zero;
      ovf_q[0]  <= in_overflow;
      res_q[0]  <= in_aluresult;
      pc_q[0]   <= in_new_pc;
      dst_q[0]  <= in_dst;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i]  <= vld_q[i-1];
        wr_q[i]   <= wr_q[i-1];
        zero_q[i] <= zero_q[i-1];
        ovf_q[i]  <= ovf_q[i-1];
        res_q[i]  <= res_q[i-1];
        pc_q[i]   <= pc_q[i-1];
        dst_q[i]  <= dst_q[i-1];
      end
    end
  end

  // Per-stage hazard taps and exception sources, gated by valid.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    assign stage_wr[g]                = vld_q[g] & wr_q[g];
    assign stage_dst[g*DST_W +: DST_W] = stage_wr[g] ? dst_q[g] : '0;
    assign exc_vec_c[g]               = vld_q[g] & ovf_q[g];
  end

  assign exc_pending = |exc_vec_c;

  // Last stage drives the outputs; stale data is hidden when not valid.
  assign out_valid = vld_q[LAST];
  assign aluresult = vld_q[LAST] ? res_q[LAST] : '0;
  assign zero      = vld_q[LAST] & zero_q[LAST];
  assign overflow  = vld_q[LAST] & ovf_q[LAST];
  assign new_pc    = vld_q[LAST] ? pc_q[LAST] : '0;
  assign dst       = vld_q[LAST] ? dst_q[LAST] : '0;
  assign regwrite  = vld_q[LAST] & wr_q[LAST];

endmodule

// File: tb/tb_exec_pipe.sv
`timescale 1ns/1ps
// Self-checking bench for exec_pipe: DEPTH=2 main instance with scoreboard,
// plus DEPTH=1 and DEPTH=8 (DATA_W=64) instances for latency/width checks.
module tb_exec_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, in_valid, in_zero, in_overflow, in_regwrite, stall, flush;
  logic [31:0] in_res, in_pc;
  logic [63:0] in_res64;
  logic [4:0]  in_dst;

  logic        m_vld, m_zero, m_ovf, m_wr, m_exc;
  logic [31:0] m_res, m_pc;
  logic [4:0]  m_dst;
  logic [9:0]  m_sdst;
  logic [1:0]  m_swr;

  logic        a_vld, a_zero, a_ovf, a_wr, a_exc;
  logic [63:0] a_res;
  logic [31:0] a_pc;
  logic [4:0]  a_dst, a_sdst;
  logic [0:0]  a_swr;

  logic        b_vld, b_zero, b_ovf, b_wr, b_exc;
  logic [63:0] b_res;
  logic [31:0] b_pc;
  logic [4:0]  b_dst;
  logic [39:0] b_sdst;
  logic [7:0]  b_swr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic [31:0] pc;
    logic [4:0]  dst;
    logic        wr;
  } exp_t;

  exp_t sb_q[$];

  exec_pipe #(.DATA_W(32), .ADDR_W(32), .DST_W(5), .DEPTH(2)) u_main (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_aluresult(in_res),
    .in_zero(in_zero), .in_overflow(in_overflow), .in_new_pc(in_pc),
    .in_dst(in_dst), .in_regwrite(in_regwrite), .stall(stall), .flush(flush),
    .out_valid(m_vld), .aluresult(m_res), .zero(m_zero), .overflow(m_ovf),
    .new_pc(m_pc), .dst(m_dst), .regwrite(m_wr), .stage_dst(m_sdst),
    .stage_wr(m_swr), .exc_pending(m_exc));

  exec_pipe #(.DATA_W(64), .ADDR_W(32), .DST_W(5), .DEPTH(1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_aluresult(in_res64),
    .in_zero(in_zero), .in_overflow(in_overflow), .in_new_pc(in_pc),
    .in_dst(in_dst), .in_regwrite(in_regwrite), .stall(stall), .flush(flush),
    .out_valid(a_vld), .aluresult(a_res), .zero(a_zero), .overflow(a_ovf),
    .new_pc(a_pc), .dst(a_dst), .regwrite(a_wr), .stage_dst(a_sdst),
    .stage_wr(a_swr), .exc_pending(a_exc));

  exec_pipe #(.DATA_W(64), .ADDR_W(32), .DST_W(5), .DEPTH(8)) u_d8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_aluresult(in_res64),
    .in_zero(in_zero), .in_overflow(in_overflow), .in_new_pc(in_pc),
    .in_dst(in_dst), .in_regwrite(in_regwrite), .stall(stall), .flush(flush),
    .out_valid(b_vld), .aluresult(b_res), .zero(b_zero), .overflow(b_ovf),
    .new_pc(b_pc), .dst(b_dst), .regwrite(b_wr), .stage_dst(b_sdst),
    .stage_wr(b_swr), .exc_pending(b_exc));

  // Scoreboard on the DEPTH=2 instance: push on accepted input, pop on exit.
  always @(negedge clk) begin : mon
    exp_t obs;
    exp_t want;
    obs = {m_res, m_zero, m_ovf, m_pc, m_dst, m_wr};
    if (!reset_n || flush) begin
      sb_q.delete();
    end else begin
      if (!stall) begin
        if (m_vld) begin
          n_checks++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: out_valid=1 dst=%0d res=%h, required no output", m_dst, m_res);
          end else begin
            want = sb_q.pop_front();
            if (obs !== want) begin
              n_fail++;
              $display("FAIL sb_entry: got %h required %h", obs, want);
            end
          end
        end
        if (in_valid)
          sb_q.push_back({in_res, in_zero, in_overflow, in_pc, in_dst,
                          in_regwrite & ~in_overflow & (in_dst != 5'd0)});
      end
      if (!m_vld) begin
        n_checks++;
        if (obs !== '0) begin
          n_fail++;
          $display("FAIL sb_gating: invalid output fields got %h required 0", obs);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] r, input logic [4:0] d,
                        input logic rw, input logic ov);
    in_valid    = v;
    in_res      = r;
    in_pc       = r ^ 32'hA5A5_0000;
    in_zero     = r[0];
    in_dst      = d;
    in_regwrite = rw;
    in_overflow = ov;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_in(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b1, 1'b0);
    in_res64 = '1;
    tick(); tick();
    n_checks++;
    if ({m_vld, m_zero, m_ovf, m_wr, m_exc, m_res, m_pc, m_dst, m_sdst, m_swr} !== '0) begin
      n_fail++; $display("FAIL reset_main: outputs got vld=%b res=%h pc=%h, required all 0", m_vld, m_res, m_pc);
    end
    n_checks++;
    if ({a_vld, a_zero, a_ovf, a_wr, a_exc, a_res, a_pc, a_dst, a_sdst, a_swr} !== '0) begin
      n_fail++; $display("FAIL reset_d1: outputs got vld=%b res=%h, required all 0", a_vld, a_res);
    end
    n_checks++;
    if ({b_vld, b_zero, b_ovf, b_wr, b_exc, b_res, b_pc, b_dst, b_sdst, b_swr} !== '0) begin
      n_fail++; $display("FAIL reset_d8: outputs got vld=%b exc=%b, required all 0", b_vld, b_exc);
    end
    reset_n = 1'b1;
    set_in(1'b1, 32'h0000_1111, 5'd3, 1'b1, 1'b1);
    tick(); tick();
    n_checks++;
    if (m_vld !== 1'b1 || m_exc !== 1'b1) begin
      n_fail++; $display("FAIL reset_midstream_pre: got vld=%b exc=%b required 1 1", m_vld, m_exc);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({m_vld, m_zero, m_ovf, m_wr, m_exc, m_res, m_pc, m_dst, m_sdst, m_swr} !== '0) begin
      n_fail++; $display("FAIL reset_async: got vld=%b exc=%b pc=%h, required all 0", m_vld, m_exc, m_pc);
    end
    set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_latency();
    set_in(1'b1, 32'h1234_5678, 5'd7, 1'b1, 1'b0);
    in_res64 = 64'h0123_4567_89AB_CDEF;
    tick();
    set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (m_vld !== 1'b0) begin
      n_fail++; $display("FAIL lat_early: out_valid got %b after 1 edge, required 0", m_vld);
    end
    n_checks++;
    if (a_vld !== 1'b1 || a_res !== 64'h0123_4567_89AB_CDEF) begin
      n_fail++; $display("FAIL lat_d1: got vld=%b res=%h required 1 0123456789abcdef", a_vld, a_res);
    end
    tick();
    n_checks++;
    if ({m_vld, m_res, m_dst, m_wr} !== {1'b1, 32'h1234_5678, 5'd7, 1'b1}) begin
      n_fail++; $display("FAIL lat_main: got vld=%b res=%h dst=%0d wr=%b required 1 12345678 7 1",
                         m_vld, m_res, m_dst, m_wr);
    end
    n_checks++;
    if (m_sdst !== {5'd7, 5'd0} || m_swr !== 2'b10) begin
      n_fail++; $display("FAIL lat_taps: got sdst=%h swr=%b required %h 10", m_sdst, m_swr, {5'd7, 5'd0});
    end
    tick();
    n_checks++;
    if (m_vld !== 1'b0) begin
      n_fail++; $display("FAIL lat_exit: out_valid got %b required 0", m_vld);
    end
  endtask

  task automatic test_stall();
    set_in(1'b1, 32'hAAAA_0001, 5'd1, 1'b1, 1'b0); tick();
    set_in(1'b1, 32'hBBBB_0002, 5'd2, 1'b1, 1'b0); tick();
    n_checks++;
    if (m_dst !== 5'd1 || m_sdst !== {5'd1, 5'd2}) begin
      n_fail++; $display("FAIL stall_pre: got dst=%0d sdst=%h required 1 %h", m_dst, m_sdst, {5'd1, 5'd2});
    end
    stall = 1'b1;
    set_in(1'b1, 32'hCCCC_0003, 5'd3, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if ({m_vld, m_dst, m_res, m_sdst} !== {1'b1, 5'd1, 32'hAAAA_0001, 5'd1, 5'd2}) begin
        n_fail++; $display("FAIL stall_hold%0d: got vld=%b dst=%0d res=%h sdst=%h required 1 1 aaaa0001 %h",
                           k, m_vld, m_dst, m_res, m_sdst, {5'd1, 5'd2});
      end
    end
    stall = 1'b0;
    tick();
    set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (m_dst !== 5'd2 || m_res !== 32'hBBBB_0002 || m_sdst !== {5'd2, 5'd3}) begin
      n_fail++; $display("FAIL stall_b: got dst=%0d res=%h sdst=%h required 2 bbbb0002 %h",
                         m_dst, m_res, m_sdst, {5'd2, 5'd3});
    end
    tick();
    n_checks++;
    if (m_dst !== 5'd3 || m_res !== 32'hCCCC_0003) begin
      n_fail++; $display("FAIL stall_c: got dst=%0d res=%h required 3 cccc0003", m_dst, m_res);
    end
    tick();
    n_checks++;
    if (m_vld !== 1'b0) begin
      n_fail++; $display("FAIL stall_dup: out_valid got %b after C, required 0", m_vld);
    end
  endtask

  task automatic test_flush();
    set_in(1'b1, 32'h0000_0044, 5'd4, 1'b1, 1'b1); tick();
    set_in(1'b1, 32'h0000_0055, 5'd5, 1'b1, 1'b0); tick();
    n_checks++;
    if (m_exc !== 1'b1 || m_swr !== 2'b01) begin
      n_fail++; $display("FAIL flush_pre: got exc=%b swr=%b required 1 01", m_exc, m_swr);
    end
    flush = 1'b1; stall = 1'b1;
    set_in(1'b1, 32'h0000_0066, 5'd6, 1'b1, 1'b0);
    tick();
    flush = 1'b0; stall = 1'b0;
    set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if ({m_vld, m_swr, m_sdst, m_exc, m_res, m_dst, m_wr, m_ovf} !== '0) begin
      n_fail++; $display("FAIL flush_clear: got vld=%b swr=%b sdst=%h exc=%b required all 0",
                         m_vld, m_swr, m_sdst, m_exc);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (m_vld !== 1'b0 || m_swr !== 2'b00) begin
        n_fail++; $display("FAIL flush_drop%0d: got vld=%b swr=%b required 0 00", k, m_vld, m_swr);
      end
    end
  endtask

  task automatic test_overflow();
    set_in(1'b1, 32'h0000_0099, 5'd9, 1'b1, 1'b1);
    n_checks++;
    if (m_exc !== 1'b0) begin
      n_fail++; $display("FAIL ovf_idle: exc_pending got %b required 0", m_exc);
    end
    tick();
    set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (m_exc !== 1'b1 || m_swr !== 2'b00 || m_sdst !== 10'd0) begin
      n_fail++; $display("FAIL ovf_capture: got exc=%b swr=%b sdst=%h required 1 00 0", m_exc, m_swr, m_sdst);
    end
    n_checks++;
    if ({a_vld, a_ovf, a_wr, a_exc, a_dst} !== {1'b1, 1'b1, 1'b0, 1'b1, 5'd9}) begin
      n_fail++; $display("FAIL ovf_d1: got vld=%b ovf=%b wr=%b exc=%b dst=%0d required 1 1 0 1 9",
                         a_vld, a_ovf, a_wr, a_exc, a_dst);
    end
    tick();
    n_checks++;
    if ({m_exc, m_vld, m_ovf, m_wr, m_dst, m_swr} !== {1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 2'b00}) begin
      n_fail++; $display("FAIL ovf_out: got exc=%b vld=%b ovf=%b wr=%b dst=%0d swr=%b required 1 1 1 0 9 00",
                         m_exc, m_vld, m_ovf, m_wr, m_dst, m_swr);
    end
    tick();
    n_checks++;
    if (m_exc !== 1'b0 || b_exc !== 1'b1) begin
      n_fail++; $display("FAIL ovf_exit: got main exc=%b d8 exc=%b required 0 1", m_exc, b_exc);
    end
  endtask

  task automatic test_r0();
    set_in(1'b1, 32'h0000_0077, 5'd0, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (m_swr !== 2'b00 || m_sdst !== 10'd0) begin
      n_fail++; $display("FAIL r0_taps: got swr=%b sdst=%h required 00 0", m_swr, m_sdst);
    end
    tick();
    n_checks++;
    if ({m_vld, m_wr, m_dst, m_res} !== {1'b1, 1'b0, 5'd0, 32'h0000_0077}) begin
      n_fail++; $display("FAIL r0_out: got vld=%b wr=%b dst=%0d res=%h required 1 0 0 00000077",
                         m_vld, m_wr, m_dst, m_res);
    end
    tick();
  endtask

  task automatic test_sweep();
    int lat1, lat8;
    logic [63:0] r1, r8;
    lat1 = 0; lat8 = 0; r1 = '0; r8 = '0;
    repeat (10) tick();
    n_checks++;
    if (b_vld !== 1'b0 || b_exc !== 1'b0) begin
      n_fail++; $display("FAIL sweep_empty: d8 got vld=%b exc=%b required 0 0", b_vld, b_exc);
    end
    set_in(1'b1, 32'hFFFF_FFFF, 5'd12, 1'b1, 1'b0);
    in_res64 = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) begin
        set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        in_res64 = '0;
      end
      if (lat1 == 0 && a_vld) begin lat1 = c; r1 = a_res; end
      if (lat8 == 0 && b_vld) begin lat8 = c; r8 = b_res; end
    end
    n_checks++;
    if (lat1 != 1) begin
      n_fail++; $display("FAIL sweep_lat1: latency got %0d required 1", lat1);
    end
    n_checks++;
    if (r1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL sweep_data1: got %h required ffffffffffffffff", r1);
    end
    n_checks++;
    if (lat8 != 8) begin
      n_fail++; $display("FAIL sweep_lat8: latency got %0d required 8", lat8);
    end
    n_checks++;
    if (r8 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL sweep_data8: got %h required ffffffffffffffff", r8);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 60; k++) begin
      stall = ($urandom_range(0, 3) == 0);
      set_in(($urandom_range(0, 3) != 0), $urandom, 5'($urandom),
             1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      tick();
    end
    stall = 1'b0;
    set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    repeat (4) tick();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_lost: %0d entries never left, required 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_overflow();
    test_r0();
    test_sweep();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
